csa_resolver: RTL and testbench

CSA_RESOLVER -- requirements
Module: csa_resolver

---
 rtl/csa_resolver.sv | 98 +++++++++
 tb/tb_csa_resolver.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/csa_resolver.sv
// Resolves a carry-save sum/carry pair into a binary result, CHUNK_W bits per cycle; out_valid rises DATA_W/CHUNK_W edges after accept.
// Backpressure: in_ready is high only in IDLE; result is held in DONE until out_ready, nothing is queued.
module csa_resolver #(
    parameter int DATA_W  = 16,
    parameter int CHUNK_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] sum_in,
    input  logic [DATA_W-1:0] carry_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              cout
);

    localparam int N     = DATA_W / CHUNK_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DATA_W-1:0]  sum_q;
    logic [DATA_W-1:0]  carry_q;
    logic [IDX_W-1:0]   idx;
    logic               chunk_cy;
    logic [CHUNK_W:0]   chunk_sum;
    logic               last_chunk;
    logic               accept;

    assign in_ready   = (state == IDLE);
    assign accept     = (state == IDLE) && in_valid;
    assign last_chunk = (idx == LAST_IDX);

    // One chunk of the ripple; the extra MSB is the carry into the next chunk.
    assign chunk_sum = {1'b0, sum_q[idx*CHUNK_W +: CHUNK_W]}
                     + {1'b0, carry_q[idx*CHUNK_W +: CHUNK_W]}
                     + {{CHUNK_W{1'b0}}, chunk_cy};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = ADD;
            ADD:     if (last_chunk) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= '0;
            carry_q   <= '0;
            idx       <= '0;
            chunk_cy  <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                sum_q    <= sum_in;
                carry_q  <= carry_in;
                idx      <= '0;
                chunk_cy <= 1'b0;
            end
            if (state == ADD) begin
                result[idx*CHUNK_W +: CHUNK_W] <= chunk_sum[CHUNK_W-1:0];
                chunk_cy                       <= chunk_sum[CHUNK_W];
                if (last_chunk) begin
                    cout      <= chunk_sum[CHUNK_W];
                    out_valid <= 1'b1;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
            if ((state == DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_csa_resolver.sv
// Directed and randomized checks of csa_resolver against an arithmetic reference of the addition.
module tb_csa_resolver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] sum_in;
    logic [15:0] carry_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        cout;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int acc_cyc    = 0;

    csa_resolver #(.DATA_W(16), .CHUNK_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned addition, split into the 16-bit result and the carry above it.
    function automatic logic [15:0] ref_sum(input logic [15:0] s, input logic [15:0] c);
        int unsigned tot;
        tot = int'(s) + int'(c);
        return 16'(tot % 65536);
    endfunction

    function automatic logic ref_cout(input logic [15:0] s, input logic [15:0] c);
        int unsigned tot;
        tot = int'(s) + int'(c);
        return (tot / 65536) != 0;
    endfunction

    // Entered #1 after an edge with the DUT in IDLE; returns #1 after the edge that raises out_valid.
    task automatic send(input logic [15:0] s, input logic [15:0] c, input string tag);
        int lat;
        chk({tag, "_in_ready_idle"}, in_ready, 1);
        sum_in   = s;
        carry_in = c;
        in_valid = 1'b1;
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        sum_in   = 16'($urandom);
        carry_in = 16'($urandom);
        chk({tag, "_in_ready_busy"}, in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 4);
        chk({tag, "_result"}, result, ref_sum(s, c));
        chk({tag, "_cout"}, cout, ref_cout(s, c));
    endtask

    initial begin
        logic [15:0] s;
        logic [15:0] c;
        logic [15:0] exp_r;
        logic        exp_c;
        logic        saw_valid;
        int          prev_acc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sum_in    = 16'h0;
        carry_in  = 16'h0;

        // Reset state
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_cout", cout, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Directed arithmetic cases
        send(16'h1234, 16'h0010, "d_1234");
        @(posedge clk); #1;
        send(16'hFFFF, 16'h0001, "d_ripple");
        @(posedge clk); #1;
        send(16'h8000, 16'h8000, "d_msb");
        @(posedge clk); #1;
        send(16'h0F0F, 16'h00F2, "d_0f0f");
        chk("d_0f0f_literal", result, 16'h1001);
        @(posedge clk); #1;
        chk("d_idle_after_done", in_ready, 1);

        // Hold in DONE with out_ready low; an in_valid pulse must be ignored
        out_ready = 1'b0;
        s = 16'($urandom);
        c = 16'($urandom);
        exp_r = ref_sum(s, c);
        exp_c = ref_cout(s, c);
        send(s, c, "stall");
        for (int j = 0; j < 5; j++) begin
            if (j == 2) begin
                in_valid = 1'b1;
                sum_in   = ~s;
                carry_in = 16'h5A5A;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("stall_result", result, exp_r);
            chk("stall_cout", cout, exp_c);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_valid", out_valid, 0);
        chk("stall_release_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("stall_no_queued_pair", out_valid, 0);

        // Reset asserted mid-cycle during ADD
        sum_in   = 16'h7777;
        carry_in = 16'h1111;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_result", result, 0);
        chk("arst_cout", cout, 0);
        chk("arst_in_ready", in_ready, 1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk); #1;
            saw_valid |= out_valid;
        end
        chk("arst_no_stale_valid", saw_valid, 0);
        send(16'h0001, 16'h0001, "arst_fresh");
        chk("arst_fresh_literal", result, 16'h0002);
        @(posedge clk); #1;

        // Back-to-back random pairs; operands scrambled right after each accept
        prev_acc = -1;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: begin s = 16'hFFFF; c = 16'($urandom_range(1, 65535)); end
                1: begin s = 16'($urandom); c = ~s; end
                default: begin s = 16'($urandom); c = 16'($urandom); end
            endcase
            send(s, c, "rnd");
            if (prev_acc >= 0) chk("rnd_accept_interval", acc_cyc - prev_acc, 6);
            prev_acc = acc_cyc;
            @(posedge clk); #1;
            chk("rnd_back_to_idle", out_valid, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
